// File: rtl/jtag_prog_pkg.sv
// Shared definitions for the JTAG programming sequencer.
//   - State encodings (RUN, DRAIN, HALTED, RST_HOLD) and the matching state enum.
//   - Output bundle type and the state-to-output decode used by the top level.
package jtag_prog_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] HALTED   = 2'd2;
    localparam logic [1:0] RST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        StRun     = RUN,
        StDrain   = DRAIN,
        StHalted  = HALTED,
        StRstHold = RST_HOLD
    } state_e;

    typedef struct packed {
        logic cpu_en;
        logic system_reset;
        logic prog_window;
        logic busy;
    } outs_t;

    function automatic outs_t decode_outputs(input state_e st);
        outs_t o;
        o = '0;
        unique case (st)
            StRun: begin
                o.cpu_en = 1'b1;
            end
            StDrain: begin
                o.busy = 1'b1;
            end
            StHalted: begin
                o.prog_window = 1'b1;
                o.busy        = 1'b1;
            end
            StRstHold: begin
                o.system_reset = 1'b1;
                o.busy         = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/jtag_sync_bit.sv
// Two-flop level synchroniser for a single asynchronous bit.
// Ports:
//   i_clk   - destination clock
//   i_reset - synchronous active-high reset, clears both flops
//   i_d     - asynchronous input level
//   o_q     - synchronised level, two i_clk edges after i_d
module jtag_sync_bit (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/jtag_prog_sequencer.sv
// Turns raw JTAG stall/reset request levels into ordered CPU-enable, system-reset and
// programming-window controls. CPUs are drained for DRAIN_CYCLES before the window opens,
// and system reset is held for at least RST_CYCLES.
// Ports:
//   i_clk            - system clock
//   i_reset          - synchronous active-high reset
//   i_jtag_stall_req - async level, high requests CPUs halted
//   i_jtag_reset_req - async level, high requests system reset
//   o_cpu_en         - per-CPU enable, all bits identical
//   o_system_reset   - system reset request (ORed externally with the global reset)
//   o_prog_window    - high while memories may be written over JTAG
//   o_busy           - high in any state other than RUN
module jtag_prog_sequencer
    import jtag_prog_pkg::*;
#(
    parameter int unsigned CPU_NUM      = 1,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_jtag_stall_req,
    input  logic               i_jtag_reset_req,
    output logic [CPU_NUM-1:0] o_cpu_en,
    output logic               o_system_reset,
    output logic               o_prog_window,
    output logic               o_busy
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    logic w_stall_s;
    logic w_reset_s;

    jtag_sync_bit u_sync_stall (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_jtag_stall_req),
        .o_q     (w_stall_s)
    );

    jtag_sync_bit u_sync_reset (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_jtag_reset_req),
        .o_q     (w_reset_s)
    );

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_reset_s_prev;
    outs_t            r_outs;
    outs_t            w_outs_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StRun;
            r_cnt          <= '0;
            r_reset_s_prev <= 1'b0;
            r_outs         <= decode_outputs(StRun);
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_reset_s_prev <= w_reset_s;
            r_outs         <= w_outs_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        if (w_reset_s && (r_state != StRstHold)) begin
            // Reset request beats everything, including a simultaneous stall.
            w_state_next = StRstHold;
            w_cnt_next   = RST_LOAD;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_stall_s) begin
                        w_state_next = StDrain;
                        w_cnt_next   = DRAIN_LOAD;
                    end
                end
                StDrain: begin
                    if (!w_stall_s) begin
                        w_state_next = StRun;
                    end else if (r_cnt == '0) begin
                        w_state_next = StHalted;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                StHalted: begin
                    if (!w_stall_s) begin
                        w_state_next = StRun;
                    end
                end
                StRstHold: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else if (!w_reset_s && !r_reset_s_prev) begin
                        // Release needs two low samples, so a long request is stretched
                        // by one cycle beyond its synchronised duration.
                        w_state_next = w_stall_s ? StHalted : StRun;
                    end
                end
                default: begin
                    w_state_next = StRun;
                end
            endcase
        end

        // Outputs are registered from the next state so they change with the state flop.
        w_outs_next = decode_outputs(w_state_next);
    end

    assign o_cpu_en       = {CPU_NUM{r_outs.cpu_en}};
    assign o_system_reset = r_outs.system_reset;
    assign o_prog_window  = r_outs.prog_window;
    assign o_busy         = r_outs.busy;

endmodule
